// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;

  // Fetch FSM: no request, request outstanding, or request whose data will be dropped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALE = 2'd2
  } fetch_state_t;

  localparam int PARCEL_W = 16;
  localparam int ADDR_MAX = 64;

  // Clears bits [1:0] so an address points at the 32-bit word that contains it.
  function automatic logic [ADDR_MAX-1:0] word_align(input logic [ADDR_MAX-1:0] addr);
    return addr & ~64'd3;
  endfunction

endpackage

// File: rtl/parcel_fifo.sv
// Parcel queue: one- or two-entry push, single pop, and flush back to empty.
module parcel_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                push_two_i,
  input  logic [PARCEL_W-1:0] first_i,
  input  logic [PARCEL_W-1:0] second_i,
  input  logic                pop_i,
  output logic [PARCEL_W-1:0] head_o,
  output logic [CW-1:0]       count_o,
  output logic [CW-1:0]       count_next_o
);

  logic [PARCEL_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic [PW-1:0]       tail_p1;

  assign tail_p1 = tail_q + PW'(1);
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // Occupancy after this cycle's flush, push and pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    count_next_o = count_q;
    if (flush_i) begin
      count_next_o = '0;
    end else begin
      count_next_o = count_q
                   + (push_i ? (push_two_i ? CW'(2) : CW'(1)) : CW'(0))
                   - (pop_i ? CW'(1) : CW'(0));
    end
  end

  // Parcel storage; the low parcel lands at the tail, the second one just after it.
  // NOTE: storage has no reset; occupancy is tracked by count, so stale contents are never read as valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q] <= first_i;
      if (push_two_i) begin
        mem_q[tail_p1] <= second_i;
      end
    end
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        tail_q <= tail_q + (push_two_i ? PW'(2) : PW'(1));
      end
      if (pop_i) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_next_o;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch controller: word fetches split into 16-bit parcels for the decoder.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int             RV       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [RV-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic [RV-1:0]       mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_data,
  input  logic                redirect,
  input  logic [RV-1:0]       redirect_pc,
  input  logic                stall,
  output logic [PARCEL_W-1:0] ins,
  output logic [RV-1:0]       ins_pc,
  output logic                idone
);

  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [RV-1:0] RESET_ALIGN = RV'(word_align(ADDR_MAX'(RESET_PC)));

  fetch_state_t  state_q, state_d;
  logic [RV-1:0] fetch_addr_q, fetch_addr_d;
  logic [RV-1:0] mem_addr_q, mem_addr_d;
  logic [RV-1:0] head_pc_q, head_pc_d;
  logic          skip_lo_q, skip_lo_d;

  logic                push;
  logic                pop;
  logic                req_free;
  logic [PARCEL_W-1:0] head;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;

  // Only a live (non-stale, non-redirected) ack delivers parcels; a redirect blocks the pop.
  assign push = (state_q == REQ) && mem_ack && !redirect;
  assign pop  = (count != '0) && !stall && !redirect;

  parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect),
    .push_i       (push),
    .push_two_i   (!skip_lo_q),
    .first_i      (skip_lo_q ? mem_data[31:16] : mem_data[15:0]),
    .second_i     (mem_data[31:16]),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next)
  );

  // Next fetch address, head PC and FSM; a new request is latched the moment the port frees up.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    head_pc_d    = head_pc_q;
    skip_lo_d    = skip_lo_q;

    if (push) begin
      fetch_addr_d = fetch_addr_q + RV'(4);
      skip_lo_d    = 1'b0;
    end
    if (pop) begin
      head_pc_d = head_pc_q + RV'(2);
    end
    if (redirect) begin
      head_pc_d    = {redirect_pc[RV-1:1], 1'b0};
      fetch_addr_d = RV'(word_align(ADDR_MAX'(redirect_pc)));
      skip_lo_d    = redirect_pc[1];
    end

    // The port is free when idle or when the outstanding request is acked this cycle.
    req_free = (state_q == IDLE) || mem_ack;
    if (!req_free) begin
      if (state_q == REQ && redirect) begin
        state_d = STALE;
      end
    end else if (count_next <= CW'(DEPTH - 2)) begin
      state_d    = REQ;
      mem_addr_d = fetch_addr_d;
    end else begin
      state_d = IDLE;
    end
  end

  // Registered fetch state; mem_req and mem_addr come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_ALIGN;
      mem_addr_q   <= RESET_ALIGN;
      head_pc_q    <= RESET_PC;
      skip_lo_q    <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      head_pc_q    <= head_pc_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = mem_addr_q;
  assign idone    = pop;
  assign ins      = pop ? head : '0;
  assign ins_pc   = head_pc_q;

endmodule
